// File: rtl/stage_phase_modulation_if.sv
// stage_phase_modulation_if: phase, modulation-memory and operator-output signals of the phase modulation stage
interface stage_phase_modulation_if;
    logic        [15:0] i_Phase;
    logic        [3:0]  i_VoiceOperator;
    logic        [15:0] i_AlgorithmWord;
    logic               i_ModulationWriteEnable;
    logic        [3:0]  i_ModulationWriteAddr;
    logic signed [15:0] i_ModulationWriteData;
    logic               i_OperatorOutputValid;
    logic        [3:0]  i_OperatorOutputAddr;
    logic signed [15:0] i_OperatorOutputData;
    logic signed [16:0] o_Phase;
    logic        [3:0]  o_VoiceOperator;
    logic        [15:0] o_AlgorithmWord;
    logic               o_Ready;

    modport master (
        output i_Phase, i_VoiceOperator, i_AlgorithmWord,
        output i_ModulationWriteEnable, i_ModulationWriteAddr, i_ModulationWriteData,
        output i_OperatorOutputValid, i_OperatorOutputAddr, i_OperatorOutputData,
        input  o_Phase, o_VoiceOperator, o_AlgorithmWord, o_Ready
    );

    modport slave (
        input  i_Phase, i_VoiceOperator, i_AlgorithmWord,
        input  i_ModulationWriteEnable, i_ModulationWriteAddr, i_ModulationWriteData,
        input  i_OperatorOutputValid, i_OperatorOutputAddr, i_OperatorOutputData,
        output o_Phase, o_VoiceOperator, o_AlgorithmWord, o_Ready
    );
endinterface

// File: rtl/stage_phase_modulation.sv
// stage_phase_modulation: adds per-slot modulation and self-feedback to the accumulated phase
`ifndef NUM_VOICE_OPERATORS
`define NUM_VOICE_OPERATORS 16
`endif

package stage_phase_modulation_pkg;
    typedef logic [3:0] VoiceOperatorID_t;
    typedef struct packed {
        logic [12:0] Reserved;
        logic [2:0]  FeedbackLevel;
    } AlgorithmWord_t;
endpackage

module stage_phase_modulation
    import stage_phase_modulation_pkg::*;
(
    input  logic i_Clock,
    input  logic i_Reset,
    stage_phase_modulation_if.slave bus
);
    typedef enum logic {CLEAR, RUN} state_t;

    state_t           state, state_next;
    VoiceOperatorID_t sweep_count;
    logic             clearing;

    logic signed [15:0] mod_mem   [`NUM_VOICE_OPERATORS];
    logic signed [15:0] hist0_mem [`NUM_VOICE_OPERATORS];
    logic signed [15:0] hist1_mem [`NUM_VOICE_OPERATORS];

    logic        [15:0] phase_s1;
    VoiceOperatorID_t   voice_s1;
    AlgorithmWord_t     algorithm_s1;
    logic signed [15:0] mod_s1, hist0_s1, hist1_s1;

    logic signed [16:0] hist_sum;
    logic        [2:0]  fb_shift;
    logic signed [15:0] fb;

    // state register and clear-sweep address counter
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state       <= CLEAR;
            sweep_count <= '0;
        end else begin
            state       <= state_next;
            sweep_count <= clearing ? sweep_count + 1'b1 : sweep_count;
        end
    end

    // leave CLEAR once the last slot has been zeroed
    always_comb begin
        state_next = state;
        if (state == CLEAR && sweep_count == VoiceOperatorID_t'(`NUM_VOICE_OPERATORS - 1))
            state_next = RUN;
    end

    // FSM outputs
    always_comb begin
        clearing   = (state == CLEAR);
        bus.o_Ready = (state == RUN);
    end

    // memory writes: sweep zeroes one slot per cycle, external writes only in RUN
    always_ff @(posedge i_Clock) begin
        if (!i_Reset) begin
            if (clearing) begin
                mod_mem[sweep_count]   <= '0;
                hist0_mem[sweep_count] <= '0;
                hist1_mem[sweep_count] <= '0;
            end else begin
                if (bus.i_ModulationWriteEnable)
                    mod_mem[bus.i_ModulationWriteAddr] <= bus.i_ModulationWriteData;
                if (bus.i_OperatorOutputValid) begin
                    hist1_mem[bus.i_OperatorOutputAddr] <= hist0_mem[bus.i_OperatorOutputAddr];
                    hist0_mem[bus.i_OperatorOutputAddr] <= bus.i_OperatorOutputData;
                end
            end
        end
    end

    // clock 1: register inputs and read the slot's memories (old value on same-cycle write)
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            phase_s1     <= '0;
            voice_s1     <= '0;
            algorithm_s1 <= '0;
            mod_s1       <= '0;
            hist0_s1     <= '0;
            hist1_s1     <= '0;
        end else begin
            phase_s1     <= bus.i_Phase;
            voice_s1     <= bus.i_VoiceOperator;
            algorithm_s1 <= AlgorithmWord_t'(bus.i_AlgorithmWord);
            mod_s1       <= mod_mem[bus.i_VoiceOperator];
            hist0_s1     <= hist0_mem[bus.i_VoiceOperator];
            hist1_s1     <= hist1_mem[bus.i_VoiceOperator];
        end
    end

    // feedback: average-style sum of the last two samples scaled by the feedback level
    always_comb begin
        hist_sum = {hist0_s1[15], hist0_s1} + {hist1_s1[15], hist1_s1};
        fb_shift = 3'(4'd8 - {1'b0, algorithm_s1.FeedbackLevel});
        fb       = (algorithm_s1.FeedbackLevel == 3'd0) ? 16'sd0 : 16'(hist_sum >>> fb_shift);
    end

    // clock 2: modulated phase wraps modulo 2^17; held at zero during the sweep
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            bus.o_Phase         <= '0;
            bus.o_VoiceOperator <= '0;
            bus.o_AlgorithmWord <= '0;
        end else begin
            bus.o_Phase         <= clearing ? 17'sd0 :
                                   17'({2'b00, phase_s1} + {{2{mod_s1[15]}}, mod_s1} + {{2{fb[15]}}, fb});
            bus.o_VoiceOperator <= voice_s1;
            bus.o_AlgorithmWord <= algorithm_s1;
        end
    end
endmodule

// File: tb/tb_stage_phase_modulation.sv
// tb_stage_phase_modulation: directed checks of sweep, modulation, feedback, wrap and read-before-write
module tb_stage_phase_modulation;
    logic i_Clock = 1'b0;
    logic i_Reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    stage_phase_modulation_if bus();

    stage_phase_modulation dut (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .bus     (bus)
    );

    always #5 i_Clock = ~i_Clock;

    task automatic step(input int n);
        repeat (n) @(negedge i_Clock);
    endtask

    task automatic idle_writes();
        bus.i_ModulationWriteEnable = 1'b0;
        bus.i_ModulationWriteAddr   = '0;
        bus.i_ModulationWriteData   = '0;
        bus.i_OperatorOutputValid   = 1'b0;
        bus.i_OperatorOutputAddr    = '0;
        bus.i_OperatorOutputData    = '0;
    endtask

    task automatic issue(input logic [15:0] phase, input logic [3:0] voice, input logic [15:0] aw);
        bus.i_Phase         = phase;
        bus.i_VoiceOperator = voice;
        bus.i_AlgorithmWord = aw;
    endtask

    task automatic mod_write(input logic [3:0] addr, input logic [15:0] data);
        bus.i_ModulationWriteEnable = 1'b1;
        bus.i_ModulationWriteAddr   = addr;
        bus.i_ModulationWriteData   = data;
        step(1);
        bus.i_ModulationWriteEnable = 1'b0;
    endtask

    task automatic hist_write(input logic [3:0] addr, input logic [15:0] data);
        bus.i_OperatorOutputValid = 1'b1;
        bus.i_OperatorOutputAddr  = addr;
        bus.i_OperatorOutputData  = data;
        step(1);
        bus.i_OperatorOutputValid = 1'b0;
    endtask

    task automatic wait_ready(output int n, output bit phase_bad);
        n = 0;
        phase_bad = 1'b0;
        while (bus.o_Ready !== 1'b1 && n < 100) begin
            if (bus.o_Phase !== 17'h0) phase_bad = 1'b1;
            @(negedge i_Clock);
            n++;
        end
    endtask

    task automatic test_reset();
        int  n;
        bit  bad;
        i_Reset = 1'b1;
        idle_writes();
        issue(16'h5555, 4'hA, 16'hFFFF);
        step(3);
        checks++; if (bus.o_Phase !== 17'h0) begin errors++; $display("FAIL reset_phase got %h want 00000", bus.o_Phase); end
        checks++; if (bus.o_VoiceOperator !== 4'h0) begin errors++; $display("FAIL reset_voice got %h want 0", bus.o_VoiceOperator); end
        checks++; if (bus.o_AlgorithmWord !== 16'h0) begin errors++; $display("FAIL reset_aw got %h want 0000", bus.o_AlgorithmWord); end
        checks++; if (bus.o_Ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", bus.o_Ready); end
        i_Reset = 1'b0;
        bus.i_ModulationWriteEnable = 1'b1;
        bus.i_ModulationWriteData   = 16'h7777;
        bus.i_OperatorOutputValid   = 1'b1;
        bus.i_OperatorOutputData    = 16'h7777;
        wait_ready(n, bad);
        idle_writes();
        checks++; if (n != 16) begin errors++; $display("FAIL sweep_len got %0d want 16", n); end
        checks++; if (bad) begin errors++; $display("FAIL sweep_phase got nonzero want 00000"); end
        issue(16'h0042, 4'h0, 16'h0007);
        step(2);
        checks++; if (bus.o_Phase !== 17'h00042) begin errors++; $display("FAIL clear_ignores_writes got %h want 00042", bus.o_Phase); end
    endtask

    task automatic test_basic();
        issue(16'h1234, 4'd3, 16'hABC0);
        step(2);
        checks++; if (bus.o_Phase !== 17'h01234) begin errors++; $display("FAIL basic_phase got %h want 01234", bus.o_Phase); end
        checks++; if (bus.o_VoiceOperator !== 4'd3) begin errors++; $display("FAIL basic_voice got %h want 3", bus.o_VoiceOperator); end
        checks++; if (bus.o_AlgorithmWord !== 16'hABC0) begin errors++; $display("FAIL basic_aw got %h want abc0", bus.o_AlgorithmWord); end
    endtask

    task automatic test_negative_mod();
        mod_write(4'd5, 16'hFF00);
        issue(16'h0080, 4'd5, 16'h0000);
        step(2);
        checks++; if (bus.o_Phase !== 17'h1FF80) begin errors++; $display("FAIL neg_mod got %h want 1ff80", bus.o_Phase); end
    endtask

    task automatic test_feedback();
        hist_write(4'd2, 16'h4000);
        hist_write(4'd2, 16'h4000);
        issue(16'h0000, 4'd2, 16'h0007);
        step(2);
        checks++; if (bus.o_Phase !== 17'h04000) begin errors++; $display("FAIL fb_level7 got %h want 04000", bus.o_Phase); end
        issue(16'h0000, 4'd2, 16'h0001);
        step(2);
        checks++; if (bus.o_Phase !== 17'h00100) begin errors++; $display("FAIL fb_level1 got %h want 00100", bus.o_Phase); end
        hist_write(4'd2, 16'hF000);
        issue(16'h0005, 4'd2, 16'h0004);
        step(2);
        checks++; if (bus.o_Phase !== 17'h00305) begin errors++; $display("FAIL fb_mixed got %h want 00305", bus.o_Phase); end
    endtask

    task automatic test_wrap();
        mod_write(4'd9, 16'h8000);
        issue(16'h0000, 4'd9, 16'h0000);
        step(2);
        checks++; if (bus.o_Phase !== 17'h18000) begin errors++; $display("FAIL wrap_min got %h want 18000", bus.o_Phase); end
        mod_write(4'd9, 16'h7FFF);
        issue(16'hFFFF, 4'd9, 16'h0000);
        step(2);
        checks++; if (bus.o_Phase !== 17'h17FFE) begin errors++; $display("FAIL wrap_max got %h want 17ffe", bus.o_Phase); end
    endtask

    task automatic test_back_to_back();
        bus.i_ModulationWriteEnable = 1'b1;
        bus.i_ModulationWriteAddr   = 4'd7;
        bus.i_ModulationWriteData   = 16'h0010;
        issue(16'h0100, 4'd7, 16'h0000);
        step(1);
        bus.i_ModulationWriteEnable = 1'b0;
        issue(16'h0100, 4'd7, 16'h0000);
        step(1);
        issue(16'h1234, 4'd3, 16'h0000);
        checks++; if (bus.o_Phase !== 17'h00100) begin errors++; $display("FAIL rbw_old got %h want 00100", bus.o_Phase); end
        step(1);
        checks++; if (bus.o_Phase !== 17'h00110) begin errors++; $display("FAIL rbw_new got %h want 00110", bus.o_Phase); end
        checks++; if (bus.o_VoiceOperator !== 4'd7) begin errors++; $display("FAIL b2b_voice7 got %h want 7", bus.o_VoiceOperator); end
        step(1);
        checks++; if (bus.o_Phase !== 17'h01234) begin errors++; $display("FAIL b2b_slot3 got %h want 01234", bus.o_Phase); end
        checks++; if (bus.o_VoiceOperator !== 4'd3) begin errors++; $display("FAIL b2b_voice3 got %h want 3", bus.o_VoiceOperator); end
    endtask

    task automatic test_reset_run();
        int          n;
        bit          bad;
        logic [3:0]  slots  [4] = '{4'd2, 4'd5, 4'd7, 4'd9};
        logic [15:0] phases [4] = '{16'h0011, 16'h2222, 16'h0333, 16'hF444};
        i_Reset = 1'b1;
        step(1);
        checks++; if (bus.o_Ready !== 1'b0) begin errors++; $display("FAIL run_reset_ready got %b want 0", bus.o_Ready); end
        checks++; if (bus.o_Phase !== 17'h0) begin errors++; $display("FAIL run_reset_phase got %h want 00000", bus.o_Phase); end
        i_Reset = 1'b0;
        step(5);
        i_Reset = 1'b1;
        step(1);
        i_Reset = 1'b0;
        wait_ready(n, bad);
        checks++; if (n != 16 || bad) begin errors++; $display("FAIL resweep got %0d cycles phase_bad %b want 16 0", n, bad); end
        for (int i = 0; i < 4; i++) begin
            issue(phases[i], slots[i], 16'h0007);
            step(2);
            checks++;
            if (bus.o_Phase !== {1'b0, phases[i]}) begin
                errors++;
                $display("FAIL cleared_slot%0d got %h want %h", slots[i], bus.o_Phase, {1'b0, phases[i]});
            end
        end
    endtask

    initial begin
        idle_writes();
        issue(16'h0, 4'h0, 16'h0);
        step(1);
        test_reset();
        test_basic();
        test_negative_mod();
        test_feedback();
        test_wrap();
        test_back_to_back();
        test_reset_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stage_phase_modulation.md
STAGE_PHASE_MODULATION -- requirements
Module: stage_phase_modulation

Interface
REQ-001 SHALL have port i_Clock, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-002 SHALL have port i_Reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port i_Phase, input, unsigned 16: accumulated phase from the phase accumulation stage.
REQ-004 SHALL have port i_VoiceOperator, input, VoiceOperatorID_t: operator slot of i_Phase.
REQ-005 SHALL have port i_AlgorithmWord, input, AlgorithmWord_t: uses field FeedbackLevel (unsigned 3).
REQ-006 SHALL have port i_ModulationWriteEnable, input, 1 bit: write strobe for the modulation memory.
REQ-007 SHALL have port i_ModulationWriteAddr, input, VoiceOperatorID_t: modulation memory write address.
REQ-008 SHALL have port i_ModulationWriteData, input, signed 16: summed modulator output for that slot.
REQ-009 SHALL have port i_OperatorOutputValid, input, 1 bit: strobe for a new operator output sample.
REQ-010 SHALL have port i_OperatorOutputAddr, input, VoiceOperatorID_t: slot that produced the sample.
REQ-011 SHALL have port i_OperatorOutputData, input, signed 16: operator output sample, feeds the feedback history.
REQ-012 SHALL have port o_Phase, output, signed 17: modulated phase for the waveform stage.
REQ-013 SHALL have ports o_VoiceOperator and o_AlgorithmWord, outputs: i_VoiceOperator and i_AlgorithmWord delayed 2 cycles.
REQ-014 SHALL have port o_Ready, output, 1 bit: high when the memory clear sweep is complete.

Function
REQ-015 SHALL hold per-slot memories of `NUM_VOICE_OPERATORS entries: ModMem (signed 16), Hist0 (signed 16, newest sample) and Hist1 (signed 16, previous sample).
REQ-016 SHALL use a 2-state FSM, CLEAR and RUN; reset enters CLEAR with sweep counter = 0.
REQ-017 In CLEAR, each cycle SHALL write 0 to ModMem, Hist0 and Hist1 at the counter address, then increment the counter.
REQ-018 In CLEAR, the FSM SHALL go to RUN on the cycle after the counter reaches `NUM_VOICE_OPERATORS-1; o_Ready = 1 exactly in RUN.
REQ-019 In CLEAR, external writes (ModulationWrite, OperatorOutput) SHALL be ignored and o_Phase SHALL be forced to 0.
REQ-020 In RUN, on i_ModulationWriteEnable: ModMem[i_ModulationWriteAddr] <= i_ModulationWriteData.
REQ-021 In RUN, on i_OperatorOutputValid: Hist1[addr] <= Hist0[addr] and Hist0[addr] <= i_OperatorOutputData.
REQ-022 Clock 1 SHALL register i_Phase, i_VoiceOperator, i_AlgorithmWord, ModMem[i_VoiceOperator], Hist0[i_VoiceOperator] and Hist1[i_VoiceOperator].
REQ-023 Memory reads SHALL be read-before-write: a same-cycle write to the read address returns the old value; the new value is visible from the next cycle.
REQ-024 Clock 2 SHALL compute Fb:
- FeedbackLevel == 0: Fb = 0.
- Otherwise: Fb = (sign-extended 17-bit sum Hist0 + Hist1) arithmetically shifted right by (8 - FeedbackLevel), truncated to signed 16.
REQ-025 Clock 2 SHALL compute o_Phase = {1'b0, phase} + sign-extended Mod + sign-extended Fb, computed at 18 bits then truncated to 17 bits (modular wrap, no saturation).
REQ-026 Latency i_* to o_* SHALL be exactly 2 cycles, with one new operator accepted every cycle and no stalls.
REQ-027 The i_VoiceOperator order SHALL be unconstrained; each slot's result depends only on that slot's memory contents.

Reset
REQ-028 On i_Reset = 1: o_Phase = 0, o_VoiceOperator = 0, o_AlgorithmWord = 0, o_Ready = 0, all pipeline registers = 0, FSM = CLEAR, counter = 0.
REQ-029 A reset asserted mid-sweep or in RUN SHALL restart the full sweep from address 0.
REQ-030 Reset SHALL take priority over all writes in the same cycle.

Verification
REQ-031 Release reset -> o_Ready stays 0 for exactly `NUM_VOICE_OPERATORS cycles, then 1; o_Phase = 0 throughout.
REQ-032 RUN, ModMem[3] = 0, no history, i_Phase = 0x1234, slot 3 -> o_Phase = 0x01234 two cycles later; o_VoiceOperator = 3.
REQ-033 ModMem[5] = -0x0100 (0xFF00), i_Phase = 0x0080, FeedbackLevel = 0 -> o_Phase = 0x1FF80 (i.e. -128).
REQ-034 Hist for slot 2 = {0x4000, 0x4000}, FeedbackLevel = 7, ModMem = 0, i_Phase = 0 -> Fb = 0x4000, o_Phase = 0x04000; with FeedbackLevel = 1 -> o_Phase = 0x00100.
REQ-035 i_ModulationWriteEnable to slot 7 with 0x0010 in the same cycle slot 7 enters -> old value used; slot 7 on the next cycle -> +0x0010 applied.
REQ-036 Assert reset in RUN after configuring memories -> full sweep repeats, then all slots produce o_Phase = {0, i_Phase}.
